// File: rtl/mem_arbiter_if.sv
// Bundle between the IF/MEM requesters, the single-port memory and the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  ram_en;
  logic                  ram_we;
  logic [BE_WIDTH-1:0]   ram_be;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_rdata,
    output if_ready, if_rdata, mem_ready, mem_rdata,
           ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_rdata,
    input  if_ready, if_rdata, mem_ready, mem_rdata,
           ram_en, ram_we, ram_be, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between IF and MEM: MEM has priority, IF is
// forced after STARVE_LIMIT consecutive MEM grants made while IF was waiting.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          busy_o
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int SW       = $clog2(STARVE_LIMIT + 1);
  localparam int LW       = $clog2(MEM_LATENCY + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                state_q;
  logic                  owner_mem_q;
  logic [SW-1:0]         starve_q;
  logic [LW-1:0]         lat_q;
  logic                  ram_en_q;
  logic                  ram_we_q;
  logic [BE_WIDTH-1:0]   ram_be_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  if_ready_q;
  logic                  mem_ready_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic                  busy_q;

  logic                  owner_mem_d;
  logic [SW-1:0]         starve_d;

  // Grant decision and starvation counter update for the IDLE cycle.
  always_comb begin
    owner_mem_d = 1'b0;
    starve_d    = '0;
    if (bus.mem_req && bus.if_req) begin
      owner_mem_d = (starve_q != STARVE_MAX);
    end else if (bus.mem_req) begin
      owner_mem_d = 1'b1;
    end else begin
      owner_mem_d = 1'b0;
    end
    if (owner_mem_d && bus.if_req) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
    end else begin
      starve_d = '0;
    end
  end

  // Sequencer: grant, one access cycle, read latency, completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_mem_q <= 1'b0;
      starve_q    <= '0;
      lat_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_req || bus.mem_req) begin
            state_q     <= ACCESS;
            owner_mem_q <= owner_mem_d;
            starve_q    <= starve_d;
            ram_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            if (owner_mem_d) begin
              ram_we_q    <= bus.mem_we;
              ram_be_q    <= bus.mem_we ? bus.mem_be : '0;
              ram_addr_q  <= bus.mem_addr;
              ram_wdata_q <= bus.mem_wdata;
            end else begin
              ram_we_q    <= 1'b0;
              ram_be_q    <= '0;
              ram_addr_q  <= bus.if_addr;
              ram_wdata_q <= '0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
          if (ram_we_q) begin
            state_q     <= DONE;
            mem_ready_q <= 1'b1;
          end else begin
            state_q <= WAIT;
            lat_q   <= LAT_LOAD;
          end
        end
        WAIT: begin
          lat_q <= lat_q - LW'(1);
          // The final latency cycle is the one where ram_rdata is valid.
          if (lat_q == LW'(1)) begin
            state_q <= DONE;
            if (owner_mem_q) begin
              mem_rdata_q <= bus.ram_rdata;
              mem_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= bus.ram_rdata;
              if_ready_q <= 1'b1;
            end
          end else begin
            state_q <= WAIT;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_be    = ram_be_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign busy_o        = busy_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer sharing the single-port instruction/data memory between the instruction-fetch (IF) stage and the memory-access (MEM) stage. It accepts held-high requests from both stages and grants one at a time: fixed priority to MEM, with a starvation limit that forces an IF grant. It drives the memory port for exactly one access cycle, waits out a configurable read latency, and returns read data with a one-cycle ready pulse to the granted stage.

## Interface
- ADDR_WIDTH, 32, address width, passed through unchanged (word address)
- DATA_WIDTH, 32, data width
- MEM_LATENCY, 1, cycles from ram_en to valid ram_rdata; legal range ≥1
- STARVE_LIMIT, 4, consecutive MEM grants with if_req pending before IF is forced; legal range ≥1

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  IF read request, held until if_ready
- if_addr  in  ADDR_WIDTH  IF read address
- if_ready  out  1  one-cycle pulse: IF read complete, if_rdata valid
- if_rdata  out  DATA_WIDTH  IF read data, held until next IF completion
- mem_req  in  1  MEM request, held until mem_ready
- mem_we  in  1  1 = write, 0 = read
- mem_be  in  DATA_WIDTH/8  write byte enables
- mem_addr  in  ADDR_WIDTH  MEM address
- mem_wdata  in  DATA_WIDTH  MEM write data
- mem_ready  out  1  one-cycle pulse: MEM access complete
- mem_rdata  out  DATA_WIDTH  MEM read data, held until next MEM read completion
- ram_en  out  1  memory access strobe, one cycle per transaction
- ram_we  out  1  memory write enable, qualified by ram_en
- ram_be  out  DATA_WIDTH/8  byte enables; 0 on reads
- ram_addr  out  ADDR_WIDTH  memory address
- ram_wdata  out  DATA_WIDTH  memory write data
- ram_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: neither request → stay. Otherwise grant, latch owner, we (forced 0 for IF), be, addr, wdata; go to ACCESS.
- Arbitration in IDLE: only one requesting → grant it. Both requesting → MEM, unless starve_cnt == STARVE_LIMIT, then IF.
- starve_cnt: on a MEM grant with if_req high, increment (saturating at STARVE_LIMIT). On an IF grant, or a MEM grant with if_req low, clear to 0.
- ACCESS: ram_en=1 with registered latched command for exactly this cycle. Write → DONE. Read → WAIT, latency counter loaded with MEM_LATENCY.
- WAIT: decrement each cycle. On the last WAIT cycle (the MEM_LATENCY-th), capture ram_rdata into owner's rdata register, then go to DONE.
- DONE: owner's ready=1 for this cycle only; requests ignored; next state IDLE.
- Request inputs are sampled only in IDLE. Deasserting a request or changing its command mid-transaction has no effect; the transaction completes and still pulses ready.
- mem_we=1 with mem_be=0 still performs an ACCESS cycle with ram_be=0.
- Non-owner rdata register and ready stay unchanged/0.

## Timing
- Reset (sync): state IDLE, starve_cnt 0, latency counter 0, ram_en/ram_we 0, ram_be/ram_addr/ram_wdata 0, if_ready/mem_ready 0, if_rdata/mem_rdata 0, busy 0.
- Reset asserted mid-transaction: IDLE on the next edge, no ready pulse, no rdata update. A write already in ACCESS is committed by memory; one not yet in ACCESS is dropped.
- Cycle 0 = IDLE cycle sampling the request. ACCESS = cycle 1. Read data on ram_rdata valid in cycle 1+MEM_LATENCY. Read ready in cycle 2+MEM_LATENCY. Write ready in cycle 2.
- Earliest next grant is the IDLE cycle following DONE. Back-to-back throughput is one read per MEM_LATENCY+3 cycles and one write per 3 cycles.
- busy high in cycles 1 through ready inclusive.
- rdata outputs are registered and stable from the ready cycle until the next same-owner read completion.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles; IF read addr 0x10, MEM_LATENCY=1, ram_rdata=0xDEADBEEF → ram_en cycle 1, if_ready cycle 3, if_rdata=0xDEADBEEF.
- MEM write addr 0x20, data 0x12345678, be=4'b0011 → ram_en=ram_we=1, ram_be=4'b0011 in cycle 1; mem_ready cycle 2; if_ready never pulses.
- Simultaneous IF and MEM held continuously, STARVE_LIMIT=4 → grant order MEM,MEM,MEM,MEM,IF,MEM…; starve_cnt returns to 0 after the IF grant.
- MEM_LATENCY=3 read, mem_req dropped in cycle 2 → capture in cycle 4, mem_ready still pulses cycle 5 with correct data.
- Reset asserted in a WAIT cycle → IDLE next cycle, no ready pulse, rdata stays 0; a new IF request afterwards completes normally.
- MEM read completes while IF waits: if_rdata unchanged, mem_rdata updated, busy low exactly one cycle between transactions.
